// File: rtl/ps2_kbd_sequencer_pkg.sv
// Shared types and constants for the PS/2 keyboard host sequencer:
// FSM state encoding, keyboard command/response bytes and byte helpers.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_WAIT_ACK_RST,
    ST_WAIT_BAT,
    ST_IDLE,
    ST_SEND_ED,
    ST_WAIT_ACK_ED,
    ST_SEND_LED,
    ST_WAIT_ACK_LED,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_LED      = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT      = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_ERR_LO   = 8'h00;
  localparam logic [7:0] RSP_ERR_HI   = 8'hFF;

  // LED argument byte for the ED command; bit order is {caps, num, scroll}.
  function automatic logic [7:0] ledByte(input logic [2:0] led);
    return {5'b00000, led};
  endfunction

  // Protocol chatter is absorbed here; only scancode traffic reaches the matrix decoder.
  function automatic logic isForwarded(input logic [7:0] b);
    return !(b == RSP_ACK    || b == RSP_RESEND || b == RSP_BAT ||
             b == RSP_ECHO   || b == RSP_ERR_LO || b == RSP_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_kbd_sequencer_if.sv
// Byte-level bundle between the sequencer, the PS/2 PHY, the LED request
// source and the keyboard matrix decoder. The sequencer is the master side.
interface ps2_kbd_sequencer_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [2:0] led_req;
  logic [7:0] scan;
  logic       scan_received;
  logic       kbd_ready;
  logic       kbd_error;

  modport master (
    input  rx_valid, rx_data, tx_ready, tx_done, led_req,
    output tx_valid, tx_data, scan, scan_received, kbd_ready, kbd_error
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, tx_done, led_req,
    input  tx_valid, tx_data, scan, scan_received, kbd_ready, kbd_error
  );

endinterface

// File: rtl/ps2_kbd_sequencer_timeout.sv
// Loadable down-counter used for both the ACK wait and the much longer BAT wait.
// A load restarts the count from 'value'; 'expired' pulses for one cycle when
// the count runs out, after which the counter stays idle until the next load.
module ps2_timeout #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic             running_q;
  logic             expired_q;

  // Count down while running; a fresh load always wins and cancels any pending expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load) begin
        count_q   <= value;
        running_q <= 1'b1;
      end else if (running_q) begin
        if (count_q <= WIDTH'(1)) begin
          count_q   <= '0;
          running_q <= 1'b0;
          expired_q <= 1'b1;
        end else begin
          count_q <= count_q - WIDTH'(1);
        end
      end
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/ps2_kbd_sequencer.sv
// PS/2 keyboard host sequencer: resets and initialises the keyboard, keeps its
// LEDs matching led_req, recovers from RESEND/timeouts, and forwards scancode
// bytes to the matrix decoder while swallowing all command/response traffic.
module ps2_kbd_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 240000,
  parameter int BAT_TIMEOUT = 24000000,
  parameter int MAX_RETRY   = 3,
  parameter int MAX_INIT    = 3
) (
  input  logic                clk,
  input  logic                rst,
  ps2_kbd_sequencer_if.master bus
);

  state_t     state_q;
  logic       txValid_q;
  logic [7:0] txData_q;
  logic       txBusy_q;
  logic [1:0] retry_q;
  logic [1:0] initFail_q;
  logic [2:0] ledShadow_q;
  logic [2:0] ledSent_q;
  logic       ledSentValid_q;
  logic       kbdReady_q;
  logic       kbdError_q;
  logic [7:0] scan_q;
  logic       scanReceived_q;

  logic        rxAck;
  logic        rxResend;
  logic        rxBat;
  logic        rxBatFail;
  logic        sendState;
  logic        inWaitAck;
  logic        forwardState;
  logic        timerLoad;
  logic [31:0] timerValue;
  logic        timerExpired;
  logic [1:0]  retryInc;
  logic [1:0]  initFailInc;
  logic        retryExhausted;
  logic        initExhausted;
  logic        ackFail;
  logic        batFail;
  logic        restart;
  logic        resend;
  logic [7:0]  sendByte;

  // Decode the incoming byte and decide recovery actions; an ACK arriving on the
  // same cycle as a timer expiry takes priority over the timeout.
  always_comb begin
    rxAck     = bus.rx_valid && (bus.rx_data == RSP_ACK);
    rxResend  = bus.rx_valid && (bus.rx_data == RSP_RESEND);
    rxBat     = bus.rx_valid && (bus.rx_data == RSP_BAT);
    rxBatFail = bus.rx_valid && (bus.rx_data == RSP_BAT_FAIL);

    sendState    = (state_q == ST_SEND_RST) || (state_q == ST_SEND_ED) ||
                   (state_q == ST_SEND_LED);
    inWaitAck    = (state_q == ST_WAIT_ACK_RST) || (state_q == ST_WAIT_ACK_ED) ||
                   (state_q == ST_WAIT_ACK_LED);
    forwardState = !((state_q == ST_SEND_RST) || (state_q == ST_WAIT_ACK_RST) ||
                     (state_q == ST_WAIT_BAT));

    retryInc       = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
    initFailInc    = (initFail_q == 2'd3) ? initFail_q : initFail_q + 2'd1;
    retryExhausted = int'(retryInc) >= MAX_RETRY;
    initExhausted  = int'(initFailInc) >= MAX_INIT;

    ackFail = inWaitAck && !rxAck && (rxResend || timerExpired);
    batFail = (state_q == ST_WAIT_BAT) && !rxBat && (rxBatFail || timerExpired);
    restart = (ackFail && retryExhausted) || batFail;
    resend  = ackFail && !retryExhausted;

    timerLoad  = (sendState && txBusy_q && bus.tx_done) ||
                 ((state_q == ST_WAIT_ACK_RST) && rxAck);
    timerValue = (state_q == ST_WAIT_ACK_RST) ? 32'(BAT_TIMEOUT) : 32'(ACK_TIMEOUT);

    sendByte = 8'h00;
    case (state_q)
      ST_SEND_RST: sendByte = CMD_RESET;
      ST_SEND_ED:  sendByte = CMD_LED;
      ST_SEND_LED: sendByte = ledByte(ledShadow_q);
      default:     sendByte = 8'h00;
    endcase
  end

  ps2_timeout #(
    .WIDTH (32)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (timerLoad),
    .value   (timerValue),
    .expired (timerExpired)
  );

  // Main controller: drives the PHY handshake, walks init and LED updates, and
  // restarts init (or gives up into ERROR) when retries run out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SEND_RST;
      txValid_q      <= 1'b0;
      txData_q       <= 8'h00;
      txBusy_q       <= 1'b0;
      retry_q        <= 2'd0;
      initFail_q     <= 2'd0;
      ledShadow_q    <= 3'b000;
      ledSent_q      <= 3'b000;
      ledSentValid_q <= 1'b0;
      kbdReady_q     <= 1'b0;
      kbdError_q     <= 1'b0;
    end else if (restart) begin
      txValid_q      <= 1'b0;
      txBusy_q       <= 1'b0;
      retry_q        <= 2'd0;
      initFail_q     <= initFailInc;
      ledSentValid_q <= 1'b0;
      kbdReady_q     <= 1'b0;
      if (initExhausted) begin
        state_q    <= ST_ERROR;
        kbdError_q <= 1'b1;
      end else begin
        state_q <= ST_SEND_RST;
      end
    end else begin
      case (state_q)
        ST_SEND_RST, ST_SEND_ED, ST_SEND_LED: begin
          if (!txValid_q && !txBusy_q) begin
            txValid_q <= 1'b1;
            txData_q  <= sendByte;
          end else if (txValid_q) begin
            if (bus.tx_ready) begin
              txValid_q <= 1'b0;
              txBusy_q  <= 1'b1;
            end
          end else if (bus.tx_done) begin
            txBusy_q <= 1'b0;
            if (state_q == ST_SEND_RST) begin
              state_q <= ST_WAIT_ACK_RST;
            end else if (state_q == ST_SEND_ED) begin
              state_q <= ST_WAIT_ACK_ED;
            end else begin
              state_q <= ST_WAIT_ACK_LED;
            end
          end
        end
        ST_WAIT_ACK_RST: begin
          if (rxAck) begin
            state_q <= ST_WAIT_BAT;
            retry_q <= 2'd0;
          end else if (resend) begin
            state_q <= ST_SEND_RST;
            retry_q <= retryInc;
          end
        end
        ST_WAIT_BAT: begin
          if (rxBat) begin
            state_q     <= ST_SEND_ED;
            ledShadow_q <= bus.led_req;
          end
        end
        ST_WAIT_ACK_ED: begin
          if (rxAck) begin
            state_q <= ST_SEND_LED;
            retry_q <= 2'd0;
          end else if (resend) begin
            state_q <= ST_SEND_ED;
            retry_q <= retryInc;
          end
        end
        ST_WAIT_ACK_LED: begin
          if (rxAck) begin
            state_q        <= ST_IDLE;
            ledSent_q      <= ledShadow_q;
            ledSentValid_q <= 1'b1;
            retry_q        <= 2'd0;
            initFail_q     <= 2'd0;
            kbdReady_q     <= 1'b1;
          end else if (resend) begin
            state_q <= ST_SEND_LED;
            retry_q <= retryInc;
          end
        end
        ST_IDLE: begin
          if (rxBat) begin
            ledSentValid_q <= 1'b0;
            ledShadow_q    <= bus.led_req;
            state_q        <= ST_SEND_ED;
          end else if (!ledSentValid_q || (bus.led_req != ledSent_q)) begin
            ledShadow_q <= bus.led_req;
            state_q     <= ST_SEND_ED;
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q <= ST_SEND_RST;
        end
      endcase
    end
  end

  // Forward scancode bytes to the matrix decoder with a one-cycle strobe,
  // except while the keyboard is being reset and has not yet passed BAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q         <= 8'h00;
      scanReceived_q <= 1'b0;
    end else begin
      scanReceived_q <= 1'b0;
      if (bus.rx_valid && forwardState && isForwarded(bus.rx_data)) begin
        scan_q         <= bus.rx_data;
        scanReceived_q <= 1'b1;
      end
    end
  end

  assign bus.tx_valid      = txValid_q;
  assign bus.tx_data       = txData_q;
  assign bus.scan          = scan_q;
  assign bus.scan_received = scanReceived_q;
  assign bus.kbd_ready     = kbdReady_q;
  assign bus.kbd_error     = kbdError_q;

endmodule

// File: doc/ps2_kbd_sequencer.md
# ps2_kbd_sequencer

Byte-level PS/2 keyboard host controller between the PS/2 serial PHY (byte receiver/transmitter) and the SAM keyboard matrix decoder. Resets and initialises the keyboard, keeps its LEDs in step with requested state, handles ACK/RESEND/timeout recovery, and forwards filtered scancode bytes as a `scan`/`scan_received` stream. All command traffic is absorbed here; the matrix decoder sees only make/break/extended codes.

## Interface
- `ACK_TIMEOUT`, default 240000: cycles to wait for an FA/FE response after `tx_done`.
- `BAT_TIMEOUT`, default 24000000: cycles to wait for AA after the reset command is ACKed.
- `MAX_RETRY`, default 3: RESEND/timeout retries per byte before the block restarts init.
- `MAX_INIT`, default 3: consecutive failed init attempts before entering ERROR.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, byte available from PHY.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `tx_valid` out 1: request to transmit `tx_data`; held until `tx_ready`.
- `tx_ready` in 1: PHY accepts byte (transfer when `tx_valid && tx_ready`).
- `tx_data` out 8: byte to send.
- `tx_done` in 1: one-cycle strobe, PHY finished clocking the byte out.
- `led_req` in 3: requested LEDs {caps, num, scroll}.
- `scan` out 8: last forwarded scancode byte, held.
- `scan_received` out 1: one-cycle pulse, `scan` is new.
- `kbd_ready` out 1: init done, in IDLE or LED update.
- `kbd_error` out 1: ERROR state reached.

## Operation
- Constants: CMD_RESET=FF, CMD_LED=ED, RSP_ACK=FA, RSP_RESEND=FE, RSP_BAT=AA.
- States: SEND_RST → WAIT_ACK_RST → WAIT_BAT → IDLE ↔ SEND_ED → WAIT_ACK_ED → SEND_LED → WAIT_ACK_LED → IDLE; ERROR.
- SEND_* states: raise `tx_valid` with the byte; on handshake, wait for `tx_done`, then enter the matching WAIT_ACK_* and load the ACK timer.
- WAIT_ACK_*: FA advances; FE or timeout re-sends the same byte, incrementing `retry`. If `retry == MAX_RETRY`, go to SEND_RST and increment `init_fail`.
- WAIT_BAT: AA → SEND_ED, with LED byte = shadow of `led_req`, then IDLE. FC or timeout → SEND_RST, incrementing `init_fail`. `init_fail == MAX_INIT` → ERROR.
- Reaching IDLE clears `retry` and `init_fail`.
- IDLE: if `led_req != led_sent`, go to SEND_ED. `led_sent` updates when the LED byte is ACKed. A `led_req` change mid-transaction is picked up on return to IDLE.
- LED data byte = {5'b0, caps, num, scroll}.
- Unsolicited AA in IDLE (hot-plug) → SEND_ED. This forces a resend by invalidating `led_sent`.
- Forwarding (all states except SEND_RST/WAIT_ACK_RST/WAIT_BAT): bytes other than FA, FE, AA, EE, 00, FF are forwarded. ERROR forwards as well, so a keyboard that never ACKs still types.
- `retry` is 2 bits and `init_fail` is 2 bits; both saturate, never wrap.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=00, `scan`=00, `scan_received`=0, `kbd_ready`=0, `kbd_error`=0. State is SEND_RST, counters are 0, and `led_sent` is invalid.
- `tx_valid` rises on the first clock after reset deassert.
- `scan_received` pulses exactly one cycle, one clock after `rx_valid`. `scan` updates on the same edge.
- Back-to-back `rx_valid` on consecutive cycles gives consecutive pulses; none are dropped.
- `tx_valid` falls on the cycle after handshake. `tx_data` is stable while `tx_valid` is high.
- A timer expiring on the same cycle as `rx_valid`=FA: the ACK wins.
- `rx_valid` while awaiting `tx_done`: filtered and forwarded per the rules, with no state change.
- `rst` asserted mid-transaction: immediate return to reset values. Any PHY transfer in flight is abandoned.

## Structure
- Package `ps2_pkg`: state enum, PS/2 command/response byte constants, and a function that builds the LED byte.
- Sub-module `ps2_timeout`: loadable down-counter with `load`, `value`, and `expired` (one-cycle pulse), shared by the ACK and BAT waits.

## Test plan
- Reset release, PHY accepts FF, FA, then AA: `tx_data` sequence FF, ED, 00. After FA to 00, `kbd_ready`=1.
- In IDLE, `led_req`=3'b100: ED then 04 sent. `rx` 1C → `scan`=1C with one pulse. `rx` FA is not forwarded.
- After ED, respond FE twice then FA: ED is sent 3 times, then 04. Three FE responses → restart with FF.
- No response after FF, for 3 init attempts: `kbd_error`=1. Then `rx` F0,1C → two `scan_received` pulses.
- In IDLE, `rx` AA: LEDs resent (ED, current LED byte). AA is not forwarded.
- `rst` pulsed during WAIT_ACK_LED: outputs return to reset values. The next transmitted byte is FF.
